// File: rtl/reg_status_table.sv
// Register status table: per-register pending bit + producer tag, CDB snoop
// that yields the one-hot register-file write enable, and source lookups for dispatch.

module reg_status_entry #(
  parameter int W_TAG = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ren,
  input  logic [W_TAG-1:0] rtag,
  input  logic             cdb_valid,
  input  logic [W_TAG-1:0] cdb_tag,
  output logic             pend,
  output logic [W_TAG-1:0] tag,
  output logic             hit,
  output logic             pend_nxt
);
  assign hit = cdb_valid & pend & (tag == cdb_tag);

  // A rename beats a same-cycle completion: the entry now waits on the new tag.
  always_comb begin
    pend_nxt = pend;
    if (flush)    pend_nxt = 1'b0;
    else if (ren) pend_nxt = 1'b1;
    else if (hit) pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      tag  <= '0;
    end else begin
      pend <= pend_nxt;
      if (ren && !flush) tag <= rtag;
    end
  end
endmodule

module reg_status_table #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      dispatch_wen,
  input  logic [W_ADDR-1:0]         dispatch_rdaddr,
  input  logic [W_TAG-1:0]          dispatch_rdtag,
  input  logic [W_ADDR-1:0]         dispatch_rsaddr,
  input  logic [W_ADDR-1:0]         dispatch_rtaddr,
  output logic                      dispatch_rspend,
  output logic [W_TAG-1:0]          dispatch_rstag,
  output logic                      dispatch_rsfwd,
  output logic                      dispatch_rtpend,
  output logic [W_TAG-1:0]          dispatch_rttag,
  output logic                      dispatch_rtfwd,
  input  logic                      cdb_valid,
  input  logic [W_TAG-1:0]          cdb_tag,
  output logic [(2**W_ADDR)-1:0]    rst_wen_onehot,
  output logic [W_ADDR:0]           busy_count
);
  localparam int N_ENTRY = 2**W_ADDR;

  logic [N_ENTRY-1:0]            pend;
  logic [N_ENTRY-1:0]            pend_nxt;
  logic [N_ENTRY-1:0]            hit;
  logic [N_ENTRY-1:0][W_TAG-1:0] tag;
  logic [W_ADDR:0]               busy_nxt;

  // r0 is architecturally constant, so it never becomes pending.
  assign pend[0]     = 1'b0;
  assign pend_nxt[0] = 1'b0;
  assign hit[0]      = 1'b0;
  assign tag[0]      = '0;

  for (genvar i = 1; i < N_ENTRY; i++) begin : g_ent
    reg_status_entry #(.W_TAG(W_TAG)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .ren       (dispatch_wen && (dispatch_rdaddr == W_ADDR'(i))),
      .rtag      (dispatch_rdtag),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .pend      (pend[i]),
      .tag       (tag[i]),
      .hit       (hit[i]),
      .pend_nxt  (pend_nxt[i])
    );
  end

  assign rst_wen_onehot = hit;

  // Lookups see pre-update state; a result on the CDB now is forwarded instead.
  assign dispatch_rsfwd  = hit[dispatch_rsaddr];
  assign dispatch_rspend = pend[dispatch_rsaddr] & ~hit[dispatch_rsaddr];
  assign dispatch_rstag  = dispatch_rspend ? tag[dispatch_rsaddr] : '0;
  assign dispatch_rtfwd  = hit[dispatch_rtaddr];
  assign dispatch_rtpend = pend[dispatch_rtaddr] & ~hit[dispatch_rtaddr];
  assign dispatch_rttag  = dispatch_rtpend ? tag[dispatch_rtaddr] : '0;

  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < N_ENTRY; i++) busy_nxt = busy_nxt + (W_ADDR+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_count <= '0;
    else        busy_count <= busy_nxt;
  end

  a_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(hit))
    else $error("reg_status_table: multiple CDB matches 0x%08h", hit);
endmodule

// File: tb/tb_reg_status_table.sv
// Scoreboard bench for reg_status_table: directed scenarios then random traffic
// against an array-based model of the register status rules.

module tb_reg_status_table;
  localparam int W_ADDR = 5;
  localparam int W_TAG  = 6;
  localparam int N      = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              dispatch_wen = 1'b0;
  logic [W_ADDR-1:0] dispatch_rdaddr = '0;
  logic [W_TAG-1:0]  dispatch_rdtag = '0;
  logic [W_ADDR-1:0] dispatch_rsaddr = '0;
  logic [W_ADDR-1:0] dispatch_rtaddr = '0;
  logic              dispatch_rspend, dispatch_rsfwd, dispatch_rtpend, dispatch_rtfwd;
  logic [W_TAG-1:0]  dispatch_rstag, dispatch_rttag;
  logic              cdb_valid = 1'b0;
  logic [W_TAG-1:0]  cdb_tag = '0;
  logic [N-1:0]      rst_wen_onehot;
  logic [W_ADDR:0]   busy_count;

  reg_status_table #(.W_ADDR(W_ADDR), .W_TAG(W_TAG)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_wen(dispatch_wen), .dispatch_rdaddr(dispatch_rdaddr),
    .dispatch_rdtag(dispatch_rdtag), .dispatch_rsaddr(dispatch_rsaddr),
    .dispatch_rtaddr(dispatch_rtaddr),
    .dispatch_rspend(dispatch_rspend), .dispatch_rstag(dispatch_rstag),
    .dispatch_rsfwd(dispatch_rsfwd), .dispatch_rtpend(dispatch_rtpend),
    .dispatch_rttag(dispatch_rttag), .dispatch_rtfwd(dispatch_rtfwd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rst_wen_onehot(rst_wen_onehot), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] oh;
    logic         rsp, rsf, rtp, rtf;
    logic [5:0]   rstg, rttg;
    logic [5:0]   busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: which registers wait, and on which tag.
  bit mp[N];
  int mt[N];

  function automatic int model_busy();
    int c = 0;
    for (int i = 0; i < N; i++) if (mp[i]) c++;
    return c;
  endfunction

  function automatic bit tag_used(int t);
    for (int i = 0; i < N; i++) if (mp[i] && mt[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit rst_n, input bit fl, input bit wen, input int rd, input int rdtag,
                     input int rs, input int rt, input bit cv, input int ctag);
    exp_t e;
    bit   h[N];
    @(negedge clk);
    reset = rst_n; flush = fl; dispatch_wen = wen;
    dispatch_rdaddr = W_ADDR'(rd); dispatch_rdtag = W_TAG'(rdtag);
    dispatch_rsaddr = W_ADDR'(rs); dispatch_rtaddr = W_ADDR'(rt);
    cdb_valid = cv; cdb_tag = W_TAG'(ctag);
    if (!rst_n) for (int i = 0; i < N; i++) begin mp[i] = 1'b0; mt[i] = 0; end
    for (int i = 0; i < N; i++) h[i] = rst_n && cv && mp[i] && (mt[i] == ctag);
    e.oh = '0;
    for (int i = 0; i < N; i++) e.oh[i] = h[i];
    e.rsf  = h[rs];
    e.rsp  = mp[rs] && !h[rs];
    e.rstg = e.rsp ? 6'(mt[rs]) : 6'd0;
    e.rtf  = h[rt];
    e.rtp  = mp[rt] && !h[rt];
    e.rttg = e.rtp ? 6'(mt[rt]) : 6'd0;
    e.busy = 6'(model_busy());
    q.push_back(e);
    if (rst_n) begin
      if (fl) begin
        for (int i = 0; i < N; i++) mp[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) if (h[i]) mp[i] = 1'b0;
        if (wen && rd != 0) begin mp[rd] = 1'b1; mt[rd] = rdtag; end
      end
    end
  endtask

  task automatic idle(input int rs, input int rt);
    cyc(1, 0, 0, 0, 0, rs, rt, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle once inputs settle after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("onehot", rst_wen_onehot, e.oh);
        chk("rspend", 32'(dispatch_rspend), 32'(e.rsp));
        chk("rstag",  32'(dispatch_rstag),  32'(e.rstg));
        chk("rsfwd",  32'(dispatch_rsfwd),  32'(e.rsf));
        chk("rtpend", 32'(dispatch_rtpend), 32'(e.rtp));
        chk("rttag",  32'(dispatch_rttag),  32'(e.rttg));
        chk("rtfwd",  32'(dispatch_rtfwd),  32'(e.rtf));
        chk("busy",   32'(busy_count),      32'(e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pl[$];
    int rd, t, ct;
    bit fl, wen, cv;
    for (int i = 0; i < N; i++) begin mp[i] = 1'b0; mt[i] = 0; end

    // Reset state.
    cyc(0, 0, 0, 0, 0, 5, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 31, 1, 0);
    // Five pending, then reset mid-run.
    for (int r = 1; r <= 5; r++) cyc(1, 0, 1, r, 19 + r, r, 0, 0, 0);
    idle(5, 1);
    cyc(0, 0, 0, 0, 0, 5, 3, 0, 0);
    idle(5, 1);
    // r7 rename and completion.
    cyc(1, 0, 1, 7, 'h12, 0, 0, 0, 0);
    idle(7, 7);
    cyc(1, 0, 0, 0, 0, 7, 0, 1, 'h12);
    idle(7, 7);
    // Rename wins over same-cycle completion.
    cyc(1, 0, 1, 3, 4, 0, 0, 0, 0);
    cyc(1, 0, 1, 3, 9, 3, 3, 1, 4);
    idle(3, 0);
    cyc(1, 0, 0, 0, 0, 3, 0, 1, 4);
    cyc(1, 0, 0, 0, 0, 3, 0, 1, 9);
    // r0 is never renamed.
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 0);
    // Fill every register, then flush alongside a completion.
    for (int r = 1; r < N; r++) cyc(1, 0, 1, r, r, r - 1, 0, 0, 0);
    idle(31, 10);
    cyc(1, 1, 0, 0, 0, 10, 31, 1, 10);
    idle(10, 31);
    // CDB tag matches but broadcast not valid.
    cyc(1, 0, 1, 2, 5, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 2, 2, 0, 5);
    idle(2, 0);

    // Random traffic with unique producer tags among pending entries.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        cyc(0, 0, 0, 0, 0, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
        continue;
      end
      fl  = ($urandom_range(0, 29) == 0);
      wen = $urandom_range(0, 1);
      rd  = $urandom_range(0, 31);
      do t = $urandom_range(0, 63); while (tag_used(t));
      cv  = ($urandom_range(0, 9) < 7);
      pl.delete();
      for (int i = 0; i < N; i++) if (mp[i]) pl.push_back(mt[i]);
      if (pl.size() != 0 && $urandom_range(0, 1)) ct = pl[$urandom_range(0, pl.size() - 1)];
      else ct = $urandom_range(0, 63);
      cyc(1, fl, wen, rd, t, $urandom_range(0, 31), $urandom_range(0, 31), cv, ct);
    end
    idle(0, 0);

    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d expected entries unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_status_table.md
Name: reg_status_table

Overview:
- Register Status Table (RST) for the Tomasulo-style out-of-order core; it is the producer side of the register file's write interface.
- Tracks, per architectural register, whether a result is pending and which reservation-station tag will produce it.
- Snoops the CDB and generates the one-hot register-file write enable, so only the youngest-pending match commits.
- Returns source-operand status (pending, tag, forward) to dispatch.

Parameters:
- W_ADDR, 5, architectural register address width; N_ENTRY = 2**W_ADDR.
- W_TAG, 6, producer tag width carried on the CDB.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears the table immediately when low.
- flush  in  1  synchronous branch-mispredict flush; clears all pending bits at the next edge.
- dispatch_wen  in  1  rename request for the instruction at dispatch.
- dispatch_rdaddr  in  W_ADDR  destination register being renamed.
- dispatch_rdtag  in  W_TAG  tag of the producing reservation-station entry.
- dispatch_rsaddr  in  W_ADDR  source RS lookup address.
- dispatch_rtaddr  in  W_ADDR  source RT lookup address.
- dispatch_rspend  out  1  RS value not yet in the register file and not on the CDB this cycle.
- dispatch_rstag  out  W_TAG  tag RS waits on; 0 when not pending.
- dispatch_rsfwd  out  1  RS completes on the CDB this cycle; dispatch takes cdb_wdata.
- dispatch_rtpend  out  1  same meaning as dispatch_rspend, for RT.
- dispatch_rttag  out  W_TAG  same meaning as dispatch_rstag, for RT.
- dispatch_rtfwd  out  1  same meaning as dispatch_rsfwd, for RT.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  W_TAG  tag of the broadcast result.
- rst_wen_onehot  out  N_ENTRY  one-hot register-file write enable, same cycle as the CDB data.
- busy_count  out  W_ADDR+1  number of registers currently pending.

Behaviour:
- State per entry i:
  - pend[i], 1 bit.
  - tag[i], W_TAG bits.
  - Entry 0 is hardwired: pend[0]=0, tag[0]=0.
- Reset (reset=0, async):
  - All pend=0 and tag=0.
  - Consequently rst_wen_onehot=0, all *pend/*fwd=0, all *tag=0, busy_count=0.
  - A reset asserted mid-operation discards all renames; the first edge after release behaves as from empty.
- CDB match (combinational): hit[i] = cdb_valid & pend[i] & (tag[i]==cdb_tag), for i!=0.
  - rst_wen_onehot = hit; zero latency, valid in the same cycle as cdb_wdata so the register file captures it at that edge.
  - Tags are unique among pending entries, so at most one bit is set.
  - In simulation, flag an error if more than one bit is set.
- Edge update, priority highest first:
  - flush: all pend cleared. rst_wen_onehot is still driven for the flush cycle, so a completing result is written.
  - dispatch_wen with rdaddr!=0: pend[rdaddr]<=1, tag[rdaddr]<=rdtag. This wins over a same-cycle hit on the same entry; the entry stays pending with the new tag while the old result is still written to the register file.
  - hit[i]: pend[i]<=0; tag[i] is left as-is (don't-care once not pending).
  - dispatch_wen with rdaddr==0: ignored.
- Source lookup (combinational, pre-update state):
  - fwd = hit[addr].
  - pend = pend[addr] & ~hit[addr].
  - tag = pend ? tag[addr] : 0.
  - Lookup reflects state before the same-cycle rename, so an instruction with rs==rd sees the previous producer.
  - addr 0 always returns pend=0, fwd=0.
- busy_count:
  - Registered popcount of pend, updated the same edge as pend.
  - Range 0..N_ENTRY-1.
  - No wrap: a rename of an already-pending register does not increment it.

Test Plan:
- Reset low mid-run with 5 entries pending -> immediately busy_count=0, rst_wen_onehot=0; lookup of r5 gives rspend=0, rstag=0.
- Rename r7 to tag 0x12 -> next cycle rs lookup of r7 gives rspend=1, rstag=0x12. Then CDB tag 0x12 -> rst_wen_onehot=0x00000080 in that cycle, rsfwd=1, rspend=0; next cycle r7 not pending and busy_count drops 1->0.
- Rename r3 to tag 4, then rename r3 to tag 9 in the same cycle as CDB tag 4 -> rst_wen_onehot bit 3 set; r3 stays pending with tag 9, busy_count=1. A later CDB with tag 4 -> onehot=0.
- Rename r0 to tag 1, then CDB tag 1 -> no state change, onehot=0, busy_count=0.
- Rename r1..r31 to tags 1..31 -> busy_count=31. Flush in the same cycle as CDB tag 10 -> onehot bit 10 set that cycle; next cycle all pend=0, busy_count=0.
- CDB with cdb_valid=0 and a matching tag -> onehot=0 and no clear.
